// File: rtl/uart_input_protocol_controller.sv
// Byte-stream command parser: decodes UART packets into control pulses and
// assembles little-endian payload words into one of NUM_IN write queues.
module uart_input_protocol_controller #(
  parameter int NUM_IN     = 2,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 270000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic [NUM_IN-1:0]     fifo_full,
  output logic [NUM_IN-1:0]     fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  sw_rst,
  output logic                  start,
  output logic                  proto_err,
  output logic                  overflow,
  output logic                  busy
);

  localparam int         BPW       = DATA_WIDTH / 8;
  localparam int         CW        = $clog2(TIMEOUT + 1);
  localparam logic [2:0] LAST_BYTE = 3'(BPW - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LEN     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            qsel_q, qsel_d;
  logic                  drop_q, drop_d;
  logic [8:0]            words_q, words_d;
  logic [2:0]            byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic [3:0]            pend_sel_q, pend_sel_d;
  logic [CW-1:0]         idle_cnt_q, idle_cnt_d;
  logic                  start_q, start_d;
  logic                  sw_rst_q, sw_rst_d;
  logic                  perr_q, perr_d;
  logic                  ovf_q, ovf_d;

  logic [NUM_IN-1:0]     wr_en;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] word;

  // The pending word is offered combinationally so it leaves one cycle after its last byte.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (pend_q && pend_sel_q == 4'(i) && !fifo_full[i]) wr_en[i] = 1'b1;
    end
  end

  assign wr_fire = |wr_en;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no branch can infer a latch.
    state_d     = state_q;
    qsel_d      = qsel_q;
    drop_d      = drop_q;
    words_d     = words_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    pend_d      = pend_q && !wr_fire;
    pend_data_d = pend_data_q;
    pend_sel_d  = pend_sel_q;
    start_d     = start_q;
    sw_rst_d    = 1'b0;
    perr_d      = 1'b0;
    ovf_d       = ovf_q;
    idle_cnt_d  = (rx_valid || state_q == S_IDLE) ? '0 : idle_cnt_q + CW'(1);

    word = asm_q;
    word[byte_cnt_q*8 +: 8] = rx_data;

    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data == 8'h01) begin
            sw_rst_d = 1'b1;
          end else if (rx_data == 8'h02) begin
            start_d = 1'b1;
          end else if (rx_data == 8'h03) begin
            start_d = 1'b0;
          end else if (rx_data[7:4] == 4'h1) begin
            qsel_d  = rx_data[3:0];
            drop_d  = (32'(rx_data[3:0]) >= 32'(NUM_IN));
            perr_d  = drop_d;
            state_d = S_LEN;
          end else begin
            perr_d = 1'b1;
          end
        end
        S_LEN: begin
          words_d    = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          byte_cnt_d = '0;
          state_d    = S_PAYLOAD;
        end
        S_PAYLOAD: begin
          asm_d = word;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            if (!drop_q) begin
              // A word arriving while the previous one is still stuck is lost.
              if (pend_q && !wr_fire) begin
                ovf_d  = 1'b1;
                perr_d = 1'b1;
              end else begin
                pend_d      = 1'b1;
                pend_data_d = word;
                pend_sel_d  = qsel_q;
              end
            end
            if (words_q == 9'd1) begin
              state_d = S_IDLE;
              drop_d  = 1'b0;
            end else begin
              words_d = words_q - 9'd1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && idle_cnt_d == CW'(TIMEOUT)) begin
      state_d    = S_IDLE;
      drop_d     = 1'b0;
      byte_cnt_d = '0;
      perr_d     = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      qsel_q      <= '0;
      drop_q      <= 1'b0;
      words_q     <= '0;
      byte_cnt_q  <= '0;
      // NOTE: data registers are reset too, since fifo_wr_data must read zero after reset.
      asm_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_sel_q  <= '0;
      idle_cnt_q  <= '0;
      start_q     <= 1'b0;
      sw_rst_q    <= 1'b0;
      perr_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      qsel_q      <= qsel_d;
      drop_q      <= drop_d;
      words_q     <= words_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_sel_q  <= pend_sel_d;
      idle_cnt_q  <= idle_cnt_d;
      start_q     <= start_d;
      sw_rst_q    <= sw_rst_d;
      perr_q      <= perr_d;
      ovf_q       <= ovf_d;
    end
  end

  assign fifo_wr_en   = wr_en;
  assign fifo_wr_data = pend_data_q;
  assign sw_rst       = sw_rst_q;
  assign start        = start_q;
  assign proto_err    = perr_q;
  assign overflow     = ovf_q;
  assign busy         = (state_q != S_IDLE) || pend_q;

endmodule

// File: tb/tb_uart_input_protocol_controller.sv
// Directed bench: a vector table for single-byte behaviour plus hand-written
// sequences for backpressure, bad queue, timeout and mid-packet reset.
module tb_uart_input_protocol_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [1:0]  fifo_full = 2'b00;
  logic [1:0]  fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        sw_rst, start, proto_err, overflow, busy;

  uart_input_protocol_controller #(
    .NUM_IN(2), .DATA_WIDTH(32), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .sw_rst(sw_rst), .start(start), .proto_err(proto_err),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic [1:0]  full;
    logic [1:0]  en;
    logic [31:0] wdata;
    logic        sw, st, pe, ov, bsy;
  } vec_t;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Per-cycle event counters sampled on the active edge.
  int          wr_cnt = 0;
  int          pe_cnt = 0;
  int          viol_cnt = 0;
  logic [31:0] last_data = '0;
  logic [1:0]  last_en = '0;

  always @(posedge clk) begin
    if (|fifo_wr_en) begin
      wr_cnt    <= wr_cnt + 1;
      last_data <= fifo_wr_data;
      last_en   <= fifo_wr_en;
    end
    if (proto_err) pe_cnt <= pe_cnt + 1;
    if (|(fifo_wr_en & fifo_full)) viol_cnt <= viol_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic step(input logic [7:0] d, input logic v);
    @(negedge clk);
    rx_data  = d;
    rx_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(8'h00, 1'b0);
  endtask

  task automatic assert_reset(input logic [7:0] d, input logic v);
    @(negedge clk);
    rst      = 1'b1;
    rx_data  = d;
    rx_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    rst      = 1'b0;
    rx_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic v, input logic [1:0] f,
                              input logic [1:0] en, input logic [31:0] wd, input logic sw,
                              input logic st, input logic pe, input logic bsy);
    vec_t r;
    r.data = d; r.valid = v; r.full = f; r.en = en; r.wdata = wd;
    r.sw = sw; r.st = st; r.pe = pe; r.ov = 1'b0; r.bsy = bsy;
    return r;
  endfunction

  function automatic logic [6:0] outs();
    return {fifo_wr_en, sw_rst, start, proto_err, overflow, busy};
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[25];
    int   bw, bp;

    vecs[0]  = mk(8'h11, 1, 2'b00, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[1]  = mk(8'h02, 1, 2'b00, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[2]  = mk(8'h78, 1, 2'b00, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[3]  = mk(8'h56, 1, 2'b00, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[4]  = mk(8'h34, 1, 2'b00, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[5]  = mk(8'h12, 1, 2'b00, 2'b10, 32'h12345678, 0, 0, 0, 1);
    vecs[6]  = mk(8'hEF, 1, 2'b00, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[7]  = mk(8'hBE, 1, 2'b00, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[8]  = mk(8'hAD, 1, 2'b00, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[9]  = mk(8'hDE, 1, 2'b00, 2'b10, 32'hDEADBEEF, 0, 0, 0, 1);
    vecs[10] = mk(8'h00, 0, 2'b00, 2'b00, 32'h0,        0, 0, 0, 0);
    vecs[11] = mk(8'h02, 1, 2'b00, 2'b00, 32'h0,        0, 1, 0, 0);
    vecs[12] = mk(8'h01, 1, 2'b00, 2'b00, 32'h0,        1, 1, 0, 0);
    vecs[13] = mk(8'h00, 0, 2'b00, 2'b00, 32'h0,        0, 1, 0, 0);
    vecs[14] = mk(8'h02, 1, 2'b00, 2'b00, 32'h0,        0, 1, 0, 0);
    vecs[15] = mk(8'h03, 1, 2'b00, 2'b00, 32'h0,        0, 0, 0, 0);
    vecs[16] = mk(8'h03, 1, 2'b00, 2'b00, 32'h0,        0, 0, 0, 0);
    vecs[17] = mk(8'h55, 1, 2'b00, 2'b00, 32'h0,        0, 0, 1, 0);
    vecs[18] = mk(8'h00, 0, 2'b00, 2'b00, 32'h0,        0, 0, 0, 0);
    vecs[19] = mk(8'h10, 1, 2'b10, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[20] = mk(8'h01, 1, 2'b10, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[21] = mk(8'hA1, 1, 2'b10, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[22] = mk(8'hB2, 1, 2'b10, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[23] = mk(8'hC3, 1, 2'b10, 2'b00, 32'h0,        0, 0, 0, 1);
    vecs[24] = mk(8'hD4, 1, 2'b10, 2'b01, 32'hD4C3B2A1, 0, 0, 0, 1);

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 7'b0);
    check("reset_wr_data", fifo_wr_data, 32'h0);
    release_reset();

    for (int i = 0; i < 25; i++) begin
      fifo_full = vecs[i].full;
      step(vecs[i].data, vecs[i].valid);
      check($sformatf("vec%0d_outputs", i), outs(),
            {vecs[i].en, vecs[i].sw, vecs[i].st, vecs[i].pe, vecs[i].ov, vecs[i].bsy});
      if (vecs[i].en != 2'b00)
        check($sformatf("vec%0d_wr_data", i), fifo_wr_data, vecs[i].wdata);
    end
    idle(1);
    check("q0_write_done_busy", busy, 1'b0);
    fifo_full = 2'b00;

    // Queue 0 held full across two whole words.
    bw = wr_cnt; bp = pe_cnt;
    fifo_full = 2'b01;
    step(8'h10, 1); step(8'h02, 1);
    step(8'h11, 1); step(8'h22, 1); step(8'h33, 1); step(8'h44, 1);
    check("full_first_held", {fifo_wr_en, busy}, 3'b001);
    step(8'hAA, 1); step(8'hBB, 1); step(8'hCC, 1); step(8'hDD, 1);
    idle(1);
    check("full_overflow", overflow, 1'b1);
    check("full_no_writes", 64'(wr_cnt - bw), 64'd0);
    check("full_one_perr", 64'(pe_cnt - bp), 64'd1);
    check("full_pending_busy", busy, 1'b1);
    fifo_full = 2'b00;
    idle(3);
    check("release_one_write", 64'(wr_cnt - bw), 64'd1);
    check("release_data", last_data, 32'h44332211);
    check("release_queue", last_en, 2'b01);
    check("release_idle", {busy, overflow}, 2'b01);

    assert_reset(8'h00, 1'b0);
    check("rst_clears_overflow", outs(), 7'b0);
    release_reset();

    // Write to a queue that does not exist.
    bw = wr_cnt; bp = pe_cnt;
    step(8'h17, 1);
    check("badq_perr", {proto_err, busy}, 2'b11);
    step(8'h01, 1);
    step(8'h01, 1); step(8'h02, 1); step(8'h03, 1); step(8'h04, 1);
    idle(2);
    check("badq_no_write", 64'(wr_cnt - bw), 64'd0);
    check("badq_single_perr", 64'(pe_cnt - bp), 64'd1);
    step(8'h02, 1);
    check("badq_then_start", {start, busy}, 2'b10);

    // Idle gap of TIMEOUT cycles inside a packet.
    bw = wr_cnt; bp = pe_cnt;
    step(8'h10, 1); step(8'h01, 1); step(8'hAA, 1);
    idle(99);
    check("timeout_not_early", 64'(pe_cnt - bp), 64'd0);
    check("timeout_still_busy", busy, 1'b1);
    idle(1);
    check("timeout_abort", {proto_err, busy, start}, 3'b101);
    idle(1);
    check("timeout_pulse_ends", proto_err, 1'b0);
    check("timeout_no_write", 64'(wr_cnt - bw), 64'd0);
    step(8'h03, 1);
    check("timeout_then_stop", {start, busy, proto_err}, 3'b000);

    // Reset in the middle of a payload, with a byte arriving on the reset edge.
    bw = wr_cnt;
    step(8'h02, 1);
    step(8'h11, 1); step(8'h01, 1); step(8'h01, 1); step(8'h02, 1);
    assert_reset(8'h55, 1'b1);
    check("midrst_outputs", outs(), 7'b0);
    check("midrst_wr_data", fifo_wr_data, 32'h0);
    release_reset();
    step(8'h02, 1);
    check("midrst_cmd_parsed", {start, busy, proto_err}, 3'b100);
    idle(8);
    check("midrst_no_write", 64'(wr_cnt - bw), 64'd0);

    check("never_write_when_full", 64'(viol_cnt), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
